// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: default widths, opcode
// encodings, FSM state encoding and the next-PC mux select.
package mips_pkg;

  localparam int          MIPS_PC_W         = 32;
  localparam logic [31:0] MIPS_HALT_OP      = 32'hFFFF_FFFF;
  localparam logic [31:0] MIPS_NOP          = 32'h0000_0000;
  localparam int          MIPS_DRAIN_CYCLES = 4;

  // Fetch-stage control state
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  // Next-PC selection
  typedef enum logic [1:0] {
    PC_HOLD   = 2'd0,
    PC_INC    = 2'd1,
    PC_TARGET = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and the
// synchronous instruction memory (slave).
interface instr_fetch_unit_if
  import mips_pkg::*;
#(
  parameter int PC_W = MIPS_PC_W
);

  logic [PC_W-1:0] imem_addr;
  logic            imem_en;
  logic [31:0]     imem_data;

  modport master (
    output imem_addr,
    output imem_en,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    input  imem_en,
    output imem_data
  );

endinterface

// File: rtl/pc_reg.sv
// Program counter with its next-PC mux (hold / +4 / redirect target).
// The mux output doubles as the memory read address, so the word at the
// new PC is registered by the memory on the same edge the PC updates.
module pc_reg
  import mips_pkg::*;
#(
  parameter int PC_W = MIPS_PC_W
) (
  input  logic            clk,
  input  logic            rst,
  input  pc_sel_e         sel_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_plus4_o,
  output logic [PC_W-1:0] pc_next_o
);

  // Redirect targets are word aligned; the low two bits are dropped
  localparam logic [PC_W-1:0] WORD_MASK = ~PC_W'(3);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Sequential increment wraps modulo 2^PC_W
  assign pc_plus4_o = pc_q + PC_W'(4);

  // Next-PC mux; reset presents address 0 so word 0 is ready right after reset
  always_comb begin
    pc_d = pc_q;
    if (rst) begin
      pc_d = '0;
    end else begin
      case (sel_i)
        PC_INC:    pc_d = pc_plus4_o;
        PC_TARGET: pc_d = target_i & WORD_MASK;
        default:   pc_d = pc_q;
      endcase
    end
  end

  // PC register
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory read
// port, fills the IF/ID register, squashes the wrong-path slot on an ID
// redirect and drains the pipeline after a HALT before reporting completion.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int          PC_W         = MIPS_PC_W,
  parameter logic [31:0] HALT_OP      = MIPS_HALT_OP,
  parameter logic [31:0] NOP          = MIPS_NOP,
  parameter int          DRAIN_CYCLES = MIPS_DRAIN_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_enable,
  input  logic                i_stall,
  input  logic                i_taken,
  input  logic [PC_W-1:0]     i_jump_address,
  instr_fetch_unit_if.master  imem,
  output logic [PC_W-1:0]     o_pc,
  output logic [31:0]         o_ifid_instr,
  output logic [PC_W-1:0]     o_ifid_pc,
  output logic                o_ifid_valid,
  output logic                o_halted,
  output logic [31:0]         o_fetch_count
);

  localparam int                CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  fetch_state_e    state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;

  logic [31:0]     ifid_instr_q, ifid_instr_d;
  logic [PC_W-1:0] ifid_pc_q, ifid_pc_d;
  logic            ifid_valid_q, ifid_valid_d;
  logic [31:0]     fetch_count_q, fetch_count_d;

  logic            adv;
  logic            is_halt;
  pc_sel_e         pc_sel;
  logic            fetch_load;
  logic            bubble_load;
  logic            halted;
  logic [PC_W-1:0] pc_cur;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] pc_next;

  // The pipeline only moves when the debug unit allows it and ID is not stalled
  assign adv     = i_enable & ~i_stall;
  assign is_halt = (imem.imem_data == HALT_OP);

  pc_reg #(
    .PC_W (PC_W)
  ) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .sel_i      (pc_sel),
    .target_i   (i_jump_address),
    .pc_o       (pc_cur),
    .pc_plus4_o (pc_plus4),
    .pc_next_o  (pc_next)
  );

  // FSM state and drain counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Next state: HALT starts the drain, which ends after DRAIN_CYCLES advancing cycles
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (adv && !i_taken && is_halt) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        if (adv) begin
          if (drain_cnt_q == DRAIN_LAST) begin
            state_d = ST_HALTED;
          end else begin
            drain_cnt_d = drain_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d     = ST_RUN;
        drain_cnt_d = '0;
      end
    endcase
  end

  // Outputs per state: PC select, IF/ID load kind and the halted flag.
  // A redirect outranks HALT detection because the word in memory is wrong-path.
  always_comb begin
    pc_sel      = PC_HOLD;
    fetch_load  = 1'b0;
    bubble_load = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (adv) begin
          if (i_taken) begin
            pc_sel      = PC_TARGET;
            bubble_load = 1'b1;
          end else begin
            fetch_load = 1'b1;
            pc_sel     = is_halt ? PC_HOLD : PC_INC;
          end
        end
      end
      ST_DRAIN: begin
        bubble_load = adv;
      end
      ST_HALTED: begin
        halted = 1'b1;
      end
      default: begin
        pc_sel = PC_HOLD;
      end
    endcase
  end

  // IF/ID and fetch-count next values: accept the fetched word or insert a bubble
  always_comb begin
    ifid_instr_d  = ifid_instr_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;
    if (fetch_load) begin
      ifid_instr_d  = imem.imem_data;
      ifid_pc_d     = pc_plus4;
      ifid_valid_d  = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end else if (bubble_load) begin
      ifid_instr_d = NOP;
      ifid_pc_d    = '0;
      ifid_valid_d = 1'b0;
    end
  end

  // IF/ID pipeline register and accepted-instruction counter
  always_ff @(posedge clk) begin
    if (rst) begin
      ifid_instr_q  <= NOP;
      ifid_pc_q     <= '0;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      ifid_instr_q  <= ifid_instr_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // Memory is always enabled so a held address simply re-reads the same word
  assign imem.imem_addr = pc_next;
  assign imem.imem_en   = 1'b1;

  assign o_pc          = pc_cur;
  assign o_ifid_instr  = ifid_instr_q;
  assign o_ifid_pc     = ifid_pc_q;
  assign o_ifid_valid  = ifid_valid_q;
  assign o_halted      = halted;
  assign o_fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a behavioural model.
module tb_instr_fetch_unit;

  localparam int          PC_W  = 32;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
  localparam int          DRAIN = 4;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        en    = 1'b1;
  logic        stall = 1'b0;
  logic        taken = 1'b0;
  logic [31:0] jaddr = 32'h0;

  logic [31:0] o_pc, o_ifid_instr, o_ifid_pc, o_fetch_count;
  logic        o_ifid_valid, o_halted;

  instr_fetch_unit_if #(.PC_W(PC_W)) imem_bus ();

  instr_fetch_unit #(
    .PC_W         (PC_W),
    .HALT_OP      (HALT),
    .NOP          (32'h0),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_enable       (en),
    .i_stall        (stall),
    .i_taken        (taken),
    .i_jump_address (jaddr),
    .imem           (imem_bus.master),
    .o_pc           (o_pc),
    .o_ifid_instr   (o_ifid_instr),
    .o_ifid_pc      (o_ifid_pc),
    .o_ifid_valid   (o_ifid_valid),
    .o_halted       (o_halted),
    .o_fetch_count  (o_fetch_count)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: 64 words, address bits [7:2]
  logic [31:0] mem [64];
  logic [31:0] mem_q;
  always @(posedge clk) mem_q <= mem[imem_bus.imem_addr[7:2]];
  assign imem_bus.imem_data = mem_q;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 fetching, 1 draining after HALT, 2 halted
  logic [31:0] m_pc, m_instr, m_ipc, m_count;
  logic        m_valid;
  int          m_mode, m_drained;
  bit          m_live = 0;

  function automatic logic [31:0] model_next_pc();
    if (rst) return 32'h0;
    if (!en || stall || m_mode != 0) return m_pc;
    if (taken) return jaddr & ~32'h3;
    if (mem[m_pc[7:2]] == HALT) return m_pc;
    return m_pc + 32'd4;
  endfunction

  task automatic model_step();
    logic [31:0] w;
    if (rst) begin
      m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_count = 0;
      m_mode = 0; m_drained = 0; m_live = 1;
    end else if (en && !stall && m_mode == 1) begin
      m_instr = 0; m_ipc = 0; m_valid = 0;
      m_drained++;
      if (m_drained == DRAIN) m_mode = 2;
    end else if (en && !stall && m_mode == 0) begin
      if (taken) begin
        m_pc = jaddr & ~32'h3;
        m_instr = 0; m_ipc = 0; m_valid = 0;
      end else begin
        w = mem[m_pc[7:2]];
        m_instr = w; m_ipc = m_pc + 32'd4; m_valid = 1;
        m_count = m_count + 32'd1;
        if (w == HALT) begin
          m_mode = 1; m_drained = 0;
        end else begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("pc", o_pc, m_pc);
        chk("imem_addr", imem_bus.imem_addr, model_next_pc());
        chk("imem_en", {31'b0, imem_bus.imem_en}, 32'd1);
        chk("ifid_valid", {31'b0, o_ifid_valid}, {31'b0, m_valid});
        chk("ifid_instr", o_ifid_instr, m_instr);
        if (m_valid) chk("ifid_pc", o_ifid_pc, m_ipc);
        chk("fetch_count", o_fetch_count, m_count);
        chk("halted", {31'b0, o_halted}, {31'b0, (m_mode == 2)});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_mem(input int halt_odds);
    logic [31:0] w;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if (w == HALT) w = 32'h0;
      if (halt_odds > 0 && $urandom_range(0, halt_odds - 1) == 0) w = HALT;
      mem[i] = w;
    end
  endtask

  task automatic reset_begin();
    rst = 1; en = 1; stall = 0; taken = 0; jaddr = 0;
    step();
  endtask

  task automatic reset_end();
    step();
    chk("rst_imem_addr", imem_bus.imem_addr, 32'h0);
    rst = 0;
  endtask

  task automatic base_prog();
    fill_mem(0);
    mem[0] = 32'h20; mem[1] = 32'h21; mem[2] = 32'h22;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  int halt_edge;

  initial begin
    // Reset state and sequential fetch
    reset_begin(); base_prog(); reset_end();
    chk("reset_pc", o_pc, 32'h0);
    chk("reset_valid", {31'b0, o_ifid_valid}, 32'd0);
    chk("reset_count", o_fetch_count, 32'd0);
    chk("reset_halted", {31'b0, o_halted}, 32'd0);
    step(); chk("seq0_instr", o_ifid_instr, 32'h20); chk("seq0_pc", o_ifid_pc, 32'd4);
    step(); chk("seq1_instr", o_ifid_instr, 32'h21); chk("seq1_pc", o_ifid_pc, 32'd8);
    step(); chk("seq2_instr", o_ifid_instr, 32'h22); chk("seq2_pc", o_ifid_pc, 32'd12);
    chk("seq_count", o_fetch_count, 32'd3);

    // Redirect to 0x40 while PC is 8
    reset_begin(); base_prog(); mem[16] = 32'h1234_0040; reset_end();
    step(); step();
    chk("br_at_pc", o_pc, 32'h8);
    taken = 1; jaddr = 32'h40;
    step();
    chk("br_bubble", {31'b0, o_ifid_valid}, 32'd0);
    chk("br_newpc", o_pc, 32'h40);
    taken = 0;
    step();
    chk("br_tgt_instr", o_ifid_instr, 32'h1234_0040);
    chk("br_tgt_pc", o_ifid_pc, 32'h44);
    chk("br_count", o_fetch_count, 32'd3);

    // Stall for two cycles with a redirect request that must be ignored
    reset_begin(); base_prog(); reset_end();
    step();
    stall = 1; taken = 1; jaddr = 32'h80;
    step(); step();
    chk("stall_pc", o_pc, 32'h4);
    chk("stall_instr", o_ifid_instr, 32'h20);
    chk("stall_ifid_pc", o_ifid_pc, 32'h4);
    stall = 0; taken = 0;
    step();
    chk("stall_resume_instr", o_ifid_instr, 32'h21);
    chk("stall_resume_pc", o_pc, 32'h8);

    // HALT at 0x0C, redirect requests during the drain are ignored
    reset_begin(); base_prog(); mem[3] = HALT; reset_end();
    step(); step(); step(); step();
    chk("halt_in_ifid", o_ifid_instr, HALT);
    chk("halt_ifid_pc", o_ifid_pc, 32'h10);
    chk("halt_pc", o_pc, 32'hC);
    chk("halt_count", o_fetch_count, 32'd4);
    taken = 1; jaddr = 32'h40;
    step(); step(); step();
    chk("drain_not_halted", {31'b0, o_halted}, 32'd0);
    step();
    chk("halted_rise", {31'b0, o_halted}, 32'd1);
    chk("halted_pc", o_pc, 32'hC);
    taken = 0;

    // Reset while halted
    rst = 1;
    step();
    chk("rsth_pc", o_pc, 32'h0);
    chk("rsth_halted", {31'b0, o_halted}, 32'd0);
    chk("rsth_count", o_fetch_count, 32'd0);
    rst = 0;
    step();
    chk("rsth_refetch", o_ifid_instr, 32'h20);
    chk("rsth_refetch_pc", o_ifid_pc, 32'h4);

    // Enable toggling: 8 enabled edges (4 fetches + 4 drain) needed
    reset_begin(); reset_end();
    halt_edge = 0;
    for (int i = 1; i <= 40; i++) begin
      en = (i % 2 == 1);
      step();
      if (o_halted && halt_edge == 0) halt_edge = i;
    end
    en = 1;
    chk("toggle_halt_edge", halt_edge, 32'd15);
    chk("toggle_count", o_fetch_count, 32'd4);

    // PC wrap from 0xFFFF_FFFC; target low bits dropped
    reset_begin(); base_prog(); mem[63] = 32'h0000_0ABC; reset_end();
    taken = 1; jaddr = 32'hFFFF_FFFF;
    step();
    chk("wrap_tgt_pc", o_pc, 32'hFFFF_FFFC);
    taken = 0;
    step();
    chk("wrap_instr", o_ifid_instr, 32'h0000_0ABC);
    chk("wrap_ifid_pc", o_ifid_pc, 32'h0);
    chk("wrap_pc", o_pc, 32'h0);

    // Randomized run
    reset_begin(); fill_mem(20); reset_end();
    for (int i = 0; i < 2500; i++) begin
      rst   = ($urandom_range(0, 99) < 2) || (m_mode == 2 && $urandom_range(0, 3) == 0);
      en    = ($urandom_range(0, 9) < 8);
      stall = ($urandom_range(0, 9) < 2);
      taken = ($urandom_range(0, 9) < 2);
      jaddr = $urandom_range(0, 255);
      step();
    end
    rst = 0; en = 1; stall = 0; taken = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
